// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM states (BOOT, RUN, HOLD, END)
//   pc_op_t       : PC register update command
//   ifid_op_t     : IF/ID register update command
//   NOP           : instruction word loaded by a bubble
//   DEFAULT_ROM_LIMIT : first byte address past the program
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD,
    END
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_LOAD
  } pc_op_t;

  typedef enum logic [1:0] {
    IFID_KEEP,
    IFID_BUBBLE,
    IFID_FETCH
  } ifid_op_t;

  localparam logic [31:0] NOP               = 32'd0;
  localparam logic [31:0] DEFAULT_ROM_LIMIT = 32'd384;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with increment / redirect / hold mux.
// Ports:
//   i_clock    : clock, rising edge
//   i_reset    : synchronous active-high reset, loads RESET_PC
//   i_op       : PC_HOLD keeps PC, PC_INC adds 4, PC_LOAD takes i_target
//   i_target   : redirect byte address (word-aligned here)
//   o_pc       : current PC
//   o_pc_plus4 : PC + 4, 32-bit modulo
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  pc_op_t      i_op,
  input  logic [31:0] i_target,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;

  // Wraps from 32'hFFFFFFFC to 0 by design.
  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_pc_next = r_pc;
    case (i_op)
      PC_INC:  w_pc_next = w_pc_plus4;
      PC_LOAD: w_pc_next = align_word(i_target);
      default: w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_pc <= RESET_PC;
    else         r_pc <= w_pc_next;
  end

  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage with fetch FSM and IF/ID pipeline register.
// Ports:
//   clock           : clock, rising edge
//   reset           : synchronous active-high reset
//   freeze          : decode hazard stall; holds PC and IF/ID
//   branch_taken    : redirect request (overrides freeze)
//   branch_addr     : redirect target byte address
//   rom_address     : ROM byte address, combinational from PC
//   rom_instruction : ROM word for rom_address (combinational)
//   pc_out          : IF/ID fetch address + 4
//   instruction_out : IF/ID instruction word
//   valid_out       : IF/ID holds a real fetch (0 = bubble)
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] ROM_LIMIT = DEFAULT_ROM_LIMIT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] rom_address,
  input  logic [31:0] rom_instruction,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out
);

  fetch_state_t r_state;
  fetch_state_t w_next_state;
  pc_op_t       w_pc_op;
  ifid_op_t     w_ifid_op;
  logic [31:0]  w_pc;
  logic [31:0]  w_pc_plus4;

  logic [31:0]  r_pc_out;
  logic [31:0]  r_instr;
  logic         r_valid;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .i_clock    (clock),
    .i_reset    (reset),
    .i_op       (w_pc_op),
    .i_target   (branch_addr),
    .o_pc       (w_pc),
    .o_pc_plus4 (w_pc_plus4)
  );

  assign rom_address = w_pc;

  // HOLD shares RUN's decision: the first edge with freeze low already
  // fetches, so a one-cycle freeze costs exactly one cycle.
  always_comb begin
    w_next_state = r_state;
    w_pc_op      = PC_HOLD;
    w_ifid_op    = IFID_KEEP;
    case (r_state)
      BOOT: begin
        w_next_state = RUN;
        w_ifid_op    = IFID_BUBBLE;
        if (branch_taken) w_pc_op = PC_LOAD;
      end
      RUN, HOLD: begin
        if (branch_taken) begin
          w_next_state = RUN;
          w_pc_op      = PC_LOAD;
          w_ifid_op    = IFID_BUBBLE;
        end else if (freeze) begin
          w_next_state = HOLD;
        end else if (w_pc >= ROM_LIMIT) begin
          w_next_state = END;
          w_ifid_op    = IFID_BUBBLE;
        end else begin
          w_next_state = RUN;
          w_pc_op      = PC_INC;
          w_ifid_op    = IFID_FETCH;
        end
      end
      END: begin
        w_ifid_op = IFID_BUBBLE;
        if (branch_taken) begin
          w_next_state = RUN;
          w_pc_op      = PC_LOAD;
        end
      end
      default: begin
        w_next_state = BOOT;
        w_ifid_op    = IFID_BUBBLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= BOOT;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc_out <= '0;
      r_instr  <= NOP;
      r_valid  <= 1'b0;
    end else begin
      case (w_ifid_op)
        IFID_BUBBLE: begin
          r_pc_out <= '0;
          r_instr  <= NOP;
          r_valid  <= 1'b0;
        end
        IFID_FETCH: begin
          r_pc_out <= w_pc_plus4;
          r_instr  <= rom_instruction;
          r_valid  <= 1'b1;
        end
        default: begin
          r_pc_out <= r_pc_out;
          r_instr  <= r_instr;
          r_valid  <= r_valid;
        end
      endcase
    end
  end

  assign pc_out          = r_pc_out;
  assign instruction_out = r_instr;
  assign valid_out       = r_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed, table-driven bench for instruction_fetch.
// Each vector applies inputs, checks rom_address before the edge, then
// checks the IF/ID outputs after the edge.
module tb_instruction_fetch;

  logic        clock;
  logic        reset;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] rom_address;
  logic [31:0] rom_instruction;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;

  int unsigned n_pass;
  int unsigned n_total;

  instruction_fetch #(
    .RESET_PC  (32'd0),
    .ROM_LIMIT (32'd384)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_addr     (branch_addr),
    .rom_address     (rom_address),
    .rom_instruction (rom_instruction),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Program image: two fixed words, every other word is C0DE_<addr>.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    if (addr == 32'd0)  return 32'h8001060A;
    if (addr == 32'd12) return 32'h04011000;
    return {16'hC0DE, addr[15:0]};
  endfunction

  always_comb begin
    rom_instruction = reset ? 32'd0 : rom_word(rom_address);
  end

  typedef struct {
    logic        rst;
    logic        frz;
    logic        br;
    logic [31:0] baddr;
    logic [31:0] e_rom;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic        e_v;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic frz, input logic br,
                     input logic [31:0] baddr, input logic [31:0] e_rom,
                     input logic [31:0] e_pc, input logic [31:0] e_ins,
                     input logic e_v);
    vecs.push_back('{rst, frz, br, baddr, e_rom, e_pc, e_ins, e_v});
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] e_pc,
                            input logic [31:0] e_ins, input logic e_v);
    check({tag, " pc_out"}, pc_out, e_pc);
    check({tag, " instruction_out"}, instruction_out, e_ins);
    check({tag, " valid_out"}, {31'd0, valid_out}, {31'd0, e_v});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n_fetch;
    bit          done;

    n_pass  = 0;
    n_total = 0;

    //   rst frz br  baddr    rom      pc_out   instr          v
    add(1, 0, 0, 32'd0,   32'd0,   32'd0,   32'd0,         0); // reset 2
    add(1, 0, 0, 32'd0,   32'd0,   32'd0,   32'd0,         0); // reset 3
    add(0, 0, 0, 32'd0,   32'd0,   32'd0,   32'd0,         0); // BOOT bubble
    add(0, 0, 0, 32'd0,   32'd0,   32'd4,   32'h8001060A,  1);
    add(0, 0, 0, 32'd0,   32'd4,   32'd8,   32'hC0DE0004,  1);
    add(0, 0, 0, 32'd0,   32'd8,   32'd12,  32'hC0DE0008,  1);
    add(0, 0, 0, 32'd0,   32'd12,  32'd16,  32'h04011000,  1);
    add(0, 0, 0, 32'd0,   32'd16,  32'd20,  32'hC0DE0010,  1);
    add(0, 1, 0, 32'd0,   32'd20,  32'd20,  32'hC0DE0010,  1); // freeze 1
    add(0, 1, 0, 32'd0,   32'd20,  32'd20,  32'hC0DE0010,  1); // freeze 2
    add(0, 0, 0, 32'd0,   32'd20,  32'd24,  32'hC0DE0014,  1); // resume
    add(0, 1, 1, 32'd302, 32'd24,  32'd0,   32'd0,         0); // branch beats freeze
    add(0, 0, 0, 32'd0,   32'd300, 32'd304, 32'hC0DE012C,  1);
    add(0, 0, 1, 32'd372, 32'd304, 32'd0,   32'd0,         0);
    add(0, 0, 0, 32'd0,   32'd372, 32'd376, 32'hC0DE0174,  1);
    add(0, 0, 0, 32'd0,   32'd376, 32'd380, 32'hC0DE0178,  1);
    add(0, 0, 0, 32'd0,   32'd380, 32'd384, 32'hC0DE017C,  1);
    add(0, 0, 0, 32'd0,   32'd384, 32'd0,   32'd0,         0); // enter END
    add(0, 0, 0, 32'd0,   32'd384, 32'd0,   32'd0,         0); // END holds
    add(0, 1, 0, 32'd0,   32'd384, 32'd0,   32'd0,         0); // freeze in END
    add(0, 0, 1, 32'd0,   32'd384, 32'd0,   32'd0,         0); // leave END
    add(0, 0, 0, 32'd0,   32'd0,   32'd4,   32'h8001060A,  1);
    add(0, 0, 0, 32'd0,   32'd4,   32'd8,   32'hC0DE0004,  1);
    add(0, 0, 1, 32'd96,  32'd8,   32'd0,   32'd0,         0);
    add(0, 0, 0, 32'd0,   32'd96,  32'd100, 32'hC0DE0060,  1);
    add(0, 1, 0, 32'd0,   32'd100, 32'd100, 32'hC0DE0060,  1); // HOLD at 100
    add(1, 1, 1, 32'd200, 32'd100, 32'd0,   32'd0,         0); // reset wins
    add(0, 0, 0, 32'd0,   32'd0,   32'd0,   32'd0,         0); // BOOT bubble
    add(0, 0, 0, 32'd0,   32'd0,   32'd4,   32'h8001060A,  1);

    reset        = 1'b1;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'd0;
    step();
    check("reset rom_address", rom_address, 32'd0);
    check_ifid("reset", 32'd0, 32'd0, 1'b0);

    foreach (vecs[i]) begin
      reset        = vecs[i].rst;
      freeze       = vecs[i].frz;
      branch_taken = vecs[i].br;
      branch_addr  = vecs[i].baddr;
      #1;
      check($sformatf("v%0d rom_address", i), rom_address, vecs[i].e_rom);
      step();
      check_ifid($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_ins, vecs[i].e_v);
    end

    // Free run from 360 to the end of the program: six fetches, then END.
    reset        = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b1;
    branch_addr  = 32'd360;
    step();
    branch_taken = 1'b0;
    check_ifid("run-out redirect", 32'd0, 32'd0, 1'b0);
    n_fetch = 0;
    done    = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      step();
      if (valid_out) n_fetch++;
      else           done = 1'b1;
    end
    check("run-out reached END", {31'd0, done}, 32'd1);
    check("run-out fetch count", n_fetch, 32'd6);
    check("run-out rom_address", rom_address, 32'd384);
    step();
    check("END rom_address held", rom_address, 32'd384);
    check_ifid("END held", 32'd0, 32'd0, 1'b0);

    // Redirect with freeze from END, then one fetch at the target.
    freeze       = 1'b1;
    branch_taken = 1'b1;
    branch_addr  = 32'd9;
    step();
    freeze       = 1'b0;
    branch_taken = 1'b0;
    check_ifid("END redirect", 32'd0, 32'd0, 1'b0);
    check("END redirect rom_address", rom_address, 32'd8);
    step();
    check_ifid("post-END fetch", 32'd12, 32'hC0DE0008, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
